conv2_sequencer: RTL and testbench
==================================

CONV2_SEQUENCER -- requirements
Module: conv2_sequencer

Interface
REQ-001 Parameter BITWIDTH, default 16, is the signed two's-complement width of partial results and output pixels.
REQ-002 Parameter OUT_DIM, default 10, is the output feature-map row and column count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request one full layer pass; sampled only in IDLE.
REQ-006 busy  output  1  pass in progress.
REQ-007 done  output  1  one-cycle pass-complete pulse.
REQ-008 pe_valid  output  1  window-request valid to the shared 5x5 dot-product unit.
REQ-009 pe_ready  input  1  dot-product unit accepts the request.
REQ-010 pe_kernel  output  1  kernel index of the request.
REQ-011 pe_chan  output  1  input-channel index of the request.
REQ-012 pe_row  output  4  window origin row, 0..OUT_DIM-1.
REQ-013 pe_col  output  4  window origin column, 0..OUT_DIM-1.
REQ-014 res_valid  input  1  dot-product result valid.
REQ-015 res_data  input  BITWIDTH  signed dot-product result.
REQ-016 out_valid  output  1  output-pixel write valid.
REQ-017 out_ready  input  1  output store accepts the pixel.
REQ-018 out_kernel  output  1  output channel of the pixel.
REQ-019 out_row, out_col  output  4 each  pixel coordinates.
REQ-020 out_data  output  BITWIDTH  signed pixel value.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, WRITE, DONE.
REQ-022 IDLE: start=1 -> ISSUE with kernel=0, row=0, col=0, chan=0, accumulator=0; start SHALL be ignored in all other states.
REQ-023 Iteration order SHALL be kernel (outermost), row, col, chan (innermost); 2 x OUT_DIM x OUT_DIM pixels, two requests per pixel.
REQ-024 ISSUE: pe_valid=1; pe_kernel/chan/row/col SHALL hold stable while pe_valid=1 and pe_ready=0; pe_ready=1 -> WAIT.
REQ-025 Only one request SHALL be outstanding; pe_valid SHALL be 0 in every state other than ISSUE.
REQ-026 WAIT: res_valid=1 -> accumulator = accumulator + res_data, wrapped to BITWIDTH bits with no saturation; if chan=0 then chan=1 and -> ISSUE, else -> WRITE.
REQ-027 res_valid SHALL be ignored outside WAIT.
REQ-028 WRITE: out_valid=1; out_data = sum of both channel results; out_kernel/row/col = current indices; outputs SHALL hold stable until out_ready=1.
REQ-029 WRITE with out_ready=1: chan=0, accumulator=0, col+1; col wraps OUT_DIM-1 -> 0 with row+1; row wraps OUT_DIM-1 -> 0 with kernel+1; from the last pixel (kernel=1, row=col=OUT_DIM-1) -> DONE, else -> ISSUE.
REQ-030 DONE: done=1 for exactly one cycle -> IDLE.
REQ-031 busy SHALL be 1 in ISSUE, WAIT, WRITE and DONE, and 0 in IDLE.
REQ-032 Per-pixel latency with pe_ready=1, res_valid returned the cycle after acceptance, and out_ready=1 SHALL be 5 cycles; a full pass SHALL assert done 2*OUT_DIM*OUT_DIM*5+1 cycles after the start cycle (1001 at defaults).
REQ-033 start=1 coincident with done SHALL be ignored; a new pass begins only on start in IDLE.

Reset
REQ-034 rst_n=0 SHALL force IDLE, all counters and the accumulator to 0, and busy, done, pe_valid and out_valid to 0 immediately, regardless of clk.
REQ-035 Reset mid-pass SHALL abandon the pass with no further pe_valid or out_valid; any later res_valid SHALL be ignored.

Verification
REQ-036 Zero-stall pass: start pulse, pe_ready=1, res_data=1 one cycle after each acceptance, out_ready=1 -> 200 writes of out_data=2 in order k0 r0 c0 .. k1 r9 c9; done at cycle 1001; busy=1 throughout.
REQ-037 Backpressure: pe_ready=0 for 3 cycles, then out_ready=0 for 4 cycles -> pe_* and out_* fields stable throughout; no duplicate or skipped pixel.
REQ-038 Wrap arithmetic: res_data=16'h7FFF then 16'h0001 -> out_data=16'h8000.
REQ-039 Delayed result: res_valid held 0 for 10 cycles in WAIT, with spurious res_valid pulses injected during ISSUE and WRITE -> spurious pulses ignored; accumulator changes only in WAIT.
REQ-040 Reset mid-pass at pixel k0 r3 c4 while in WAIT -> outputs 0 asynchronously; a subsequent start restarts at k0 r0 c0, chan 0.

Source files
------------

// File: rtl/conv2_sequencer_if.sv
// rtl/conv2_sequencer_if.sv - request, result and pixel-write channels of the conv2 sequencer
interface conv2_sequencer_if #(
    parameter int BITWIDTH = 16
);
    logic                       pe_valid;
    logic                       pe_ready;
    logic                       pe_kernel;
    logic                       pe_chan;
    logic [3:0]                 pe_row;
    logic [3:0]                 pe_col;
    logic                       res_valid;
    logic signed [BITWIDTH-1:0] res_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_kernel;
    logic [3:0]                 out_row;
    logic [3:0]                 out_col;
    logic signed [BITWIDTH-1:0] out_data;

    modport master (
        output pe_valid, pe_kernel, pe_chan, pe_row, pe_col,
        input  pe_ready,
        input  res_valid, res_data,
        output out_valid, out_kernel, out_row, out_col, out_data,
        input  out_ready
    );

    modport slave (
        input  pe_valid, pe_kernel, pe_chan, pe_row, pe_col,
        output pe_ready,
        output res_valid, res_data,
        input  out_valid, out_kernel, out_row, out_col, out_data,
        output out_ready
    );
endinterface

// File: rtl/conv2_sequencer.sv
// rtl/conv2_sequencer.sv - walks kernel/row/col/chan, issues 5x5 window requests, sums two channels per pixel
module conv2_sequencer #(
    parameter int BITWIDTH = 16,
    parameter int OUT_DIM  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic done,
    conv2_sequencer_if.master bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    localparam logic [3:0] LAST = 4'(OUT_DIM - 1);

    state_t                     state, state_n;
    logic                       kernel, kernel_n;
    logic                       chan, chan_n;
    logic [3:0]                 row, row_n;
    logic [3:0]                 col, col_n;
    logic signed [BITWIDTH-1:0] acc, acc_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            kernel <= 1'b0;
            chan   <= 1'b0;
            row    <= '0;
            col    <= '0;
            acc    <= '0;
        end else begin
            state  <= state_n;
            kernel <= kernel_n;
            chan   <= chan_n;
            row    <= row_n;
            col    <= col_n;
            acc    <= acc_n;
        end
    end

    always_comb begin
        state_n  = state;
        kernel_n = kernel;
        chan_n   = chan;
        row_n    = row;
        col_n    = col;
        acc_n    = acc;
        busy     = (state != IDLE);
        done     = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_n  = ISSUE;
                    kernel_n = 1'b0;
                    chan_n   = 1'b0;
                    row_n    = '0;
                    col_n    = '0;
                    acc_n    = '0;
                end
            end
            ISSUE: begin
                if (bus.pe_ready) state_n = WAIT;
            end
            WAIT: begin
                // Accumulator wraps naturally at BITWIDTH; no saturation
                if (bus.res_valid) begin
                    acc_n = acc + bus.res_data;
                    if (!chan) begin
                        chan_n  = 1'b1;
                        state_n = ISSUE;
                    end else begin
                        state_n = WRITE;
                    end
                end
            end
            WRITE: begin
                if (bus.out_ready) begin
                    chan_n  = 1'b0;
                    acc_n   = '0;
                    state_n = (kernel && row == LAST && col == LAST) ? DONE : ISSUE;
                    if (col == LAST) begin
                        col_n = '0;
                        if (row == LAST) begin
                            row_n    = '0;
                            kernel_n = ~kernel;
                        end else begin
                            row_n = row + 4'd1;
                        end
                    end else begin
                        col_n = col + 4'd1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.pe_valid   = (state == ISSUE);
    assign bus.pe_kernel  = kernel;
    assign bus.pe_chan    = chan;
    assign bus.pe_row     = row;
    assign bus.pe_col     = col;
    assign bus.out_valid  = (state == WRITE);
    assign bus.out_kernel = kernel;
    assign bus.out_row    = row;
    assign bus.out_col    = col;
    assign bus.out_data   = acc;
endmodule

// File: tb/tb_conv2_sequencer.sv
// tb/tb_conv2_sequencer.sv - scoreboard and vector-table bench for conv2_sequencer
module tb_conv2_sequencer;
    localparam int BW   = 16;
    localparam int OD   = 10;
    localparam int NPIX = 2 * OD * OD;
    localparam int NV   = 6;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic        k;
        logic [3:0]  r;
        logic [3:0]  c;
        logic [15:0] d;
        bit          stall;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;

    conv2_sequencer_if #(.BITWIDTH(BW)) bus ();

    conv2_sequencer #(.BITWIDTH(BW), .OUT_DIM(OD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[NV];
    pix_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_pass(input bit stress, input bit use_vec, input bit abort, output int done_cyc);
        int          cyc = 0;
        int          res_cnt = -1;
        int          pe_hold = 0;
        int          out_hold = 0;
        int          pix = 0;
        int          busy_low = 0;
        bit          fin = 0;
        bit          aborted = 0;
        bit          abort_now = 0;
        logic        mk = 0;
        logic        mch = 0;
        logic [3:0]  mr = 0;
        logic [3:0]  mc = 0;
        logic [15:0] rv = 0;
        logic [9:0]  pe_sig, pe_snap;
        logic [24:0] out_sig, out_snap;
        pix_t        e;
        bit          vsel;
        done_cyc = -1;
        pe_snap = '0;
        out_snap = '0;
        sb.delete();
        @(negedge clk);
        start = 1'b1;
        while (!fin && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            start = stress ? 1'($urandom_range(0, 1)) : 1'b0;
            if (abort_now) begin
                rst_n = 1'b0;
                #1;
                check("reset_async_outputs", {busy, done, bus.pe_valid, bus.out_valid}, 4'b0000);
                aborted = 1;
                fin = 1;
            end else begin
                if (!busy) busy_low++;
                if (res_cnt == 0) begin
                    bus.res_valid = 1'b1;
                    bus.res_data  = rv;
                    res_cnt = -1;
                end else begin
                    if (res_cnt > 0) res_cnt--;
                    bus.res_valid = stress && (bus.pe_valid || bus.out_valid);
                    bus.res_data  = 16'h5A5A;
                end
                bus.pe_ready = 1'b0;
                if (bus.pe_valid) begin
                    pe_sig = {bus.pe_kernel, bus.pe_chan, bus.pe_row, bus.pe_col};
                    if (pe_hold > 0) check("pe_stable", 32'(pe_sig), 32'(pe_snap));
                    else pe_snap = pe_sig;
                    if (stress && pix % 7 == 3 && pe_hold < 3) begin
                        pe_hold++;
                    end else begin
                        bus.pe_ready = 1'b1;
                        pe_hold = 0;
                        check("pe_order", 32'(pe_sig), 32'({mk, mch, mr, mc}));
                        vsel = use_vec && pix < NV;
                        res_cnt = (stress && pix % 11 == 5) ? 10 : 0;
                        abort_now = abort && !mch && !mk && mr == 4'd3 && mc == 4'd4;
                        if (!mch) begin
                            rv  = vsel ? vecs[pix].a : 16'd1;
                            mch = 1'b1;
                        end else begin
                            rv = vsel ? vecs[pix].b : 16'd1;
                            e.k = mk;
                            e.r = mr;
                            e.c = mc;
                            e.d = vsel ? vecs[pix].exp : 16'd2;
                            e.stall = stress && pix % 7 == 3;
                            sb.push_back(e);
                            mch = 1'b0;
                            pix++;
                            if (mc == 4'(OD - 1)) begin
                                mc = 0;
                                if (mr == 4'(OD - 1)) begin
                                    mr = 0;
                                    mk = ~mk;
                                end else mr = mr + 4'd1;
                            end else mc = mc + 4'd1;
                        end
                    end
                end
                bus.out_ready = 1'b0;
                if (bus.out_valid) begin
                    out_sig = {bus.out_kernel, bus.out_row, bus.out_col, bus.out_data};
                    if (sb.size() == 0) begin
                        check("write_unexpected", 32'(out_sig), 32'hFFFF_FFFF);
                    end else begin
                        if (out_hold > 0) check("out_stable", 32'(out_sig), 32'(out_snap));
                        else out_snap = out_sig;
                        if (sb[0].stall && out_hold < 4) begin
                            out_hold++;
                        end else begin
                            bus.out_ready = 1'b1;
                            out_hold = 0;
                            e = sb.pop_front();
                            check("write", 32'(out_sig), 32'({e.k, e.r, e.c, e.d}));
                        end
                    end
                end
                if (done) begin
                    done_cyc = cyc;
                    fin = 1;
                    start = 1'b1;
                end
            end
        end
        bus.pe_ready  = 1'b0;
        bus.out_ready = 1'b0;
        bus.res_valid = 1'b0;
        if (!fin) check("done_timeout", 32'(cyc), 32'd0);
        if (!aborted) begin
            @(negedge clk);
            start = 1'b0;
            check("idle_after_done", {busy, done}, 2'b00);
            check("pixel_count", 32'(pix), 32'(NPIX));
            check("scoreboard_empty", 32'(sb.size()), 32'd0);
            check("busy_throughout", 32'(busy_low), 32'd0);
        end
        start = 1'b0;
    endtask

    int dc;

    initial begin
        vecs[0] = '{16'h7FFF, 16'h0001, 16'h8000};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFE};
        vecs[2] = '{16'h8000, 16'h8000, 16'h0000};
        vecs[3] = '{16'h1234, 16'h4321, 16'h5555};
        vecs[4] = '{16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{16'h7FFF, 16'h7FFF, 16'hFFFE};
        bus.pe_ready  = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {busy, done, bus.pe_valid, bus.out_valid}, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        run_pass(0, 0, 0, dc);
        check("done_cycle_zero_stall", 32'(dc), 32'd1001);

        run_pass(1, 1, 0, dc);

        run_pass(1, 0, 1, dc);
        repeat (2) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 16'h0100;
            @(negedge clk);
            check("held_in_reset", {busy, bus.pe_valid, bus.out_valid}, 3'b000);
        end
        rst_n = 1'b1;
        repeat (3) begin
            bus.res_valid = 1'b1;
            bus.res_data  = 16'h0100;
            @(negedge clk);
            check("idle_after_reset", {busy, done, bus.pe_valid, bus.out_valid}, 4'b0000);
        end
        bus.res_valid = 1'b0;

        run_pass(0, 0, 0, dc);
        check("done_cycle_restart", 32'(dc), 32'd1001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
